// File: rtl/lamp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lamp_ctrl_pkg
// Purpose : Shared constants for the three-location lamp controller: default
//           auto-off counter width, default terminal count, and the lamp
//           ON/OFF drive levels.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package lamp_ctrl_pkg;

    // Default auto-off counter width in bits
    localparam int unsigned LAMP_CNT_W   = 8;

    // Default terminal count; the lamp stays lit for LAMP_CNT_MAX+1 cycles
    localparam int unsigned LAMP_CNT_MAX = 255;

    // Lamp drive levels
    localparam logic LAMP_ON  = 1'b1;
    localparam logic LAMP_OFF = 1'b0;

endpackage : lamp_ctrl_pkg

// File: rtl/lamp_btn_edge.sv
// ----------------------------------------------------------------------------
// lamp_btn_edge
// Purpose : Brings one asynchronous push-button into the clock domain with a
//           two-flop synchronizer, then emits a single-cycle press pulse on
//           the synchronized rising edge. A held button yields one pulse only.
// Ports   :
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset, clears all three flops
//   btn_i    in   raw asynchronous button level, active high
//   press_o  out  one-cycle pulse per press (combinational from flops)
// ----------------------------------------------------------------------------
module lamp_btn_edge
    import lamp_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer pair followed by a previous-value flop. Clearing all three
    // on reset means a button held through reset is re-sampled from zero, so
    // it is seen as a fresh press once reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Rising edge of the synchronized level
    assign press_o = sync2_q & ~prev_q;

endmodule : lamp_btn_edge

// File: rtl/lamp_ctrl.sv
// ----------------------------------------------------------------------------
// lamp_ctrl
// Purpose : Three-location (stairwell style) lamp controller. Any of three
//           momentary buttons toggles the lamp; an odd number of simultaneous
//           presses toggles, an even number cancels out. While lit, an
//           auto-off counter extinguishes the lamp after C_MAX+1 cycles.
// Parameters:
//   C_NUM   auto-off counter width in bits
//   C_MAX   terminal count, lamp lit for C_MAX+1 cycles if untouched
// Ports   :
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   S1   in   button 1, asynchronous, active high
//   S2   in   button 2, asynchronous, active high
//   S3   in   button 3, asynchronous, active high
//   F    out  registered lamp drive, 1 = lamp on
// ----------------------------------------------------------------------------
module lamp_ctrl
    import lamp_ctrl_pkg::*;
#(
    parameter int               C_NUM = LAMP_CNT_W,
    parameter logic [C_NUM-1:0] C_MAX = C_NUM'(LAMP_CNT_MAX)
) (
    input  logic clk,
    input  logic rst,
    input  logic S1,
    input  logic S2,
    input  logic S3,
    output logic F
);

    logic             press1;
    logic             press2;
    logic             press3;
    logic             tog;
    logic             lamp_q;
    logic             lamp_d;
    logic [C_NUM-1:0] cnt_q;
    logic [C_NUM-1:0] cnt_d;

    lamp_btn_edge u_btn1 (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (S1),
        .press_o (press1)
    );

    lamp_btn_edge u_btn2 (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (S2),
        .press_o (press2)
    );

    lamp_btn_edge u_btn3 (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (S3),
        .press_o (press3)
    );

    // Two simultaneous presses cancel; one or three toggle
    assign tog = press1 ^ press2 ^ press3;

    // Next lamp state and auto-off count. A toggle arriving on the timeout
    // cycle still ends with the lamp off: both paths lead to OFF and the
    // off-state never lights on the same edge it was entered.
    always_comb begin
        lamp_d = lamp_q;
        cnt_d  = cnt_q;
        if (lamp_q == LAMP_OFF) begin
            cnt_d = '0;
            if (tog) begin
                lamp_d = LAMP_ON;
            end
        end else if (tog || (cnt_q == C_MAX)) begin
            lamp_d = LAMP_OFF;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + C_NUM'(1);
        end
    end

    // Lamp bit and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_q <= LAMP_OFF;
            cnt_q  <= '0;
        end else begin
            lamp_q <= lamp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign F = lamp_q;

endmodule : lamp_ctrl

// File: tb/tb_lamp_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lamp_ctrl
// Purpose : Directed self-checking bench for lamp_ctrl. Each stimulus step
//           pushes the lamp/counter values it should cause, tagged with the
//           clock cycle they must appear in, and a checker pops and compares
//           them on the falling edge of that cycle.
// Ports   : none (top-level bench)
// ----------------------------------------------------------------------------
module tb_lamp_ctrl;

    typedef struct {
        int         cyc;
        bit         isCnt;
        logic [7:0] val;
        string      tag;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    s1;
    logic    s2;
    logic    s3;
    logic    lampF;

    int      cyc    = 0;
    int      checks = 0;
    int      errors = 0;
    int      c0;
    int      c1;
    int      c2;
    expect_t sb[$];

    lamp_ctrl dut (
        .clk (clk),
        .rst (rst),
        .S1  (s1),
        .S2  (s2),
        .S3  (s3),
        .F   (lampF)
    );

    // 20 ns clock; rising edges at 10, 30, 50 ... so cycle n ends at 10+20(n-1)
    always #10 clk = ~clk;

    // Cycle index equals the number of rising edges seen so far
    always @(posedge clk) cyc++;

    // Queue an expected lamp (isCnt=0) or counter (isCnt=1) value for a cycle
    task automatic expectAt(input int c, input bit isCnt, input logic [7:0] v, input string tag);
        expect_t e;
        e.cyc   = c;
        e.isCnt = isCnt;
        e.val   = v;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    // Drive the three buttons as {S3,S2,S1}
    task automatic applyStimulus(input logic [2:0] b);
        s1 = b[0];
        s2 = b[1];
        s3 = b[2];
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitFor(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pop and compare every entry due in the current cycle
    task automatic checkOutput();
        expect_t    e;
        logic [7:0] obs;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            obs = e.isCnt ? dut.cnt_q : {7'd0, lampF};
            checks++;
            assert (obs === e.val && e.cyc == cyc) else begin
                errors++;
                $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", e.tag, e.cyc, obs, e.val);
            end
        end
    endtask

    always @(negedge clk) checkOutput();

    // Wait, with a cycle budget, until every queued expectation is consumed
    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL drain: observed %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(3'b000);

        // Reset for two edges, lamp and counter clear
        $display("[TB] reset");
        expectAt(1, 0, 8'd0, "rst_F1");
        expectAt(1, 1, 8'd0, "rst_cnt1");
        expectAt(2, 0, 8'd0, "rst_F2");
        expectAt(10, 0, 8'd0, "idle_F");
        expectAt(10, 1, 8'd0, "idle_cnt");
        waitFor(2);
        rst = 1'b0;

        // Single S1 pulse at t=600 ns, then untouched timeout after 256 cycles
        $display("[TB] single press and timeout");
        waitFor(30);
        c0 = cyc;
        applyStimulus(3'b001);
        expectAt(c0 + 2,   0, 8'd0,   "lat_F_before");
        expectAt(c0 + 3,   0, 8'd1,   "lat_F_on");
        expectAt(c0 + 3,   1, 8'd0,   "on_cnt0");
        expectAt(c0 + 103, 1, 8'd100, "cnt_100");
        expectAt(c0 + 258, 0, 8'd1,   "to_F_last");
        expectAt(c0 + 258, 1, 8'd255, "to_cnt_max");
        expectAt(c0 + 259, 0, 8'd0,   "to_F_off");
        expectAt(c0 + 259, 1, 8'd0,   "to_cnt_clr");
        tick(1);
        applyStimulus(3'b000);
        drain();

        // S2 lights, S3 50 cycles later switches off manually
        $display("[TB] manual on/off");
        c0 = cyc;
        applyStimulus(3'b010);
        expectAt(c0 + 2, 0, 8'd0, "s2_F_before");
        expectAt(c0 + 3, 0, 8'd1, "s2_F_on");
        tick(1);
        applyStimulus(3'b000);
        waitFor(c0 + 50);
        c1 = cyc;
        applyStimulus(3'b100);
        expectAt(c1 + 2,  1, 8'd49, "s3_cnt49");
        expectAt(c1 + 2,  0, 8'd1,  "s3_F_before");
        expectAt(c1 + 3,  0, 8'd0,  "s3_F_off");
        expectAt(c1 + 3,  1, 8'd0,  "s3_cnt_clr");
        expectAt(c1 + 10, 0, 8'd0,  "s3_F_stays");
        tick(1);
        applyStimulus(3'b000);
        drain();

        // Simultaneous presses: two cancel, three toggle
        $display("[TB] simultaneous presses");
        c0 = cyc;
        applyStimulus(3'b011);
        expectAt(c0 + 3, 0, 8'd0, "pair_no_on");
        expectAt(c0 + 6, 0, 8'd0, "pair_still_off");
        tick(1);
        applyStimulus(3'b000);
        drain();
        c0 = cyc;
        applyStimulus(3'b111);
        expectAt(c0 + 2, 0, 8'd0, "tri_F_before");
        expectAt(c0 + 3, 0, 8'd1, "tri_F_on");
        tick(1);
        applyStimulus(3'b000);
        waitFor(c0 + 10);
        c1 = cyc;
        applyStimulus(3'b101);
        expectAt(c1 + 3, 0, 8'd1,  "pair_keeps_on");
        expectAt(c1 + 3, 1, 8'd10, "pair_cnt10");
        tick(1);
        applyStimulus(3'b000);
        waitFor(c1 + 10);
        c2 = cyc;
        applyStimulus(3'b111);
        expectAt(c2 + 2, 0, 8'd1, "tri_F_before_off");
        expectAt(c2 + 3, 0, 8'd0, "tri_F_off");
        tick(1);
        applyStimulus(3'b000);
        drain();

        // S3 held 1000 cycles: one toggle, timeout, no re-light
        $display("[TB] held button");
        c0 = cyc;
        applyStimulus(3'b100);
        expectAt(c0 + 3,   0, 8'd1, "hold_F_on");
        expectAt(c0 + 258, 0, 8'd1, "hold_F_last");
        expectAt(c0 + 259, 0, 8'd0, "hold_F_timeout");
        expectAt(c0 + 259, 1, 8'd0, "hold_cnt_clr");
        expectAt(c0 + 600, 0, 8'd0, "hold_F_mid");
        expectAt(c0 + 999, 0, 8'd0, "hold_F_end");
        tick(1000);
        applyStimulus(3'b000);
        expectAt(c0 + 1010, 0, 8'd0, "release_F");
        drain();

        // Press whose event lands on the timeout cycle
        $display("[TB] press on timeout cycle");
        c0 = cyc;
        applyStimulus(3'b001);
        expectAt(c0 + 3, 0, 8'd1, "tc_F_on");
        tick(1);
        applyStimulus(3'b000);
        waitFor(c0 + 256);
        c1 = cyc;
        applyStimulus(3'b010);
        expectAt(c1 + 2,  0, 8'd1,   "tc_F_last");
        expectAt(c1 + 2,  1, 8'd255, "tc_cnt_max");
        expectAt(c1 + 3,  0, 8'd0,   "tc_F_off");
        expectAt(c1 + 3,  1, 8'd0,   "tc_cnt_clr");
        expectAt(c1 + 12, 0, 8'd0,   "tc_no_relight");
        tick(1);
        applyStimulus(3'b000);
        drain();

        // Reset while lit, with a press that starts and ends inside reset
        $display("[TB] reset while on");
        c0 = cyc;
        applyStimulus(3'b001);
        expectAt(c0 + 3,  0, 8'd1, "ro_F_on");
        expectAt(c0 + 20, 0, 8'd1, "ro_F_before_rst");
        tick(1);
        applyStimulus(3'b000);
        waitFor(c0 + 20);
        rst = 1'b1;
        applyStimulus(3'b001);
        expectAt(c0 + 21, 0, 8'd0, "ro_F_rst");
        expectAt(c0 + 21, 1, 8'd0, "ro_cnt_rst");
        expectAt(c0 + 30, 0, 8'd0, "ro_no_event");
        tick(2);
        applyStimulus(3'b000);
        tick(1);
        rst = 1'b0;
        drain();

        // Button held across reset release gives exactly one event
        $display("[TB] press held through reset");
        c0 = cyc;
        rst = 1'b1;
        applyStimulus(3'b010);
        expectAt(c0 + 2, 0, 8'd0, "hr_F_rst");
        expectAt(c0 + 4, 0, 8'd0, "hr_F_before");
        expectAt(c0 + 5, 0, 8'd1, "hr_F_on");
        tick(2);
        rst = 1'b0;
        tick(3);
        applyStimulus(3'b000);
        waitFor(c0 + 10);
        applyStimulus(3'b001);
        expectAt(c0 + 13, 0, 8'd0, "hr_F_off");
        tick(1);
        applyStimulus(3'b000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lamp_ctrl
